// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first.
// Result and carry-out are latched on the final shift and held until the next completion.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             sbit,
    output logic             sbit_valid
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             p, s, c_nxt, last;

    // full adder built from a half-adder XOR pair
    always_comb begin
        p     = a_sh[0] ^ b_sh[0];
        s     = p ^ carry;
        c_nxt = (a_sh[0] & b_sh[0]) | (p & carry);
        last  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            sum        <= '0;
            cout       <= 1'b0;
            sbit       <= 1'b0;
            sbit_valid <= 1'b0;
        end else begin
            sbit_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= cin;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh       <= a_sh >> 1;
                    b_sh       <= b_sh >> 1;
                    carry      <= c_nxt;
                    res        <= {s, res[WIDTH-1:1]};
                    sbit       <= s;
                    sbit_valid <= 1'b1;
                    // hold the counter on the last shift so it never wraps mid-operation
                    cnt        <= last ? cnt : cnt + 1'b1;
                    if (last) begin
                        sum  <= {s, res[WIDTH-1:1]};
                        cout <= c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-004 SHALL have port start  input  1  request to load operands; honoured only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled on the accepting edge only.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled on the accepting edge only.
REQ-007 SHALL have port cin  input  1  carry-in, sampled on the accepting edge only.
REQ-008 SHALL have port busy  output  1  high while in RUN or DONE.
REQ-009 SHALL have port done  output  1  single-cycle pulse; sum and cout are valid and updated.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until the next completion.
REQ-011 SHALL have port cout  output  1  registered carry-out, held with sum.
REQ-012 SHALL have port sbit  output  1  serial sum bit produced by the most recent shift, LSB first.
REQ-013 SHALL have port sbit_valid  output  1  high for the cycle after each RUN shift edge.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE, held in a registered state variable.
REQ-015 In IDLE with start=1 at an edge, SHALL load the a/b shift registers, carry<=cin, bit counter<=0, and enter RUN.
REQ-016 In IDLE with start=0, SHALL remain in IDLE with all registers unchanged.
REQ-017 Per RUN edge: s=A[0]^B[0]^carry (half-adder XOR pair), carry<=majority(A[0],B[0],carry); A and B shift right by one.
REQ-018 Per RUN edge: s SHALL shift into the internal result register at its MSB, bit counter +1, sbit<=s, sbit_valid<=1.
REQ-019 On the RUN edge where the counter equals WIDTH-1, SHALL copy the completed result into sum, the new carry into cout, and enter DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-021 Latency SHALL be fixed: accepting edge E, shifts at E+1..E+WIDTH, done high in the cycle following edge E+WIDTH.
REQ-022 start SHALL be ignored in RUN and DONE; there is no queueing, and a/b/cin changes during RUN SHALL NOT affect the result.
REQ-023 sbit_valid SHALL be 0 in every cycle not immediately following a RUN shift edge; sbit holds its last value.
REQ-024 sum/cout SHALL change only on the completing RUN edge and SHALL be stable at all other times.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with the overflow bit in cout; {cout,sum} SHALL equal a+b+cin.
REQ-026 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap inside a single operation.

Reset
REQ-027 While rst_n=0: state=IDLE; busy, done, sum, cout, sbit, sbit_valid, carry and counter all 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; sum/cout SHALL read 0.
REQ-029 start=1 on the first edge after reset release SHALL be accepted normally.

Verification
REQ-030 a=8'h00, b=8'h00, cin=0, start pulse -> busy for 9 cycles, done pulse after 8 shifts, sum=8'h00, cout=0.
REQ-031 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; sbit sequence 0,0,0,0,0,0,0,0.
REQ-032 a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1; a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0, sbit LSB-first 1,1,0,1,0,0,1,0.
REQ-033 Pulse start again at shift 3 with different operands -> ignored; result equals the first operands' sum, done pulses once.
REQ-034 Assert rst_n=0 after shift 4 -> outputs 0 immediately, no done pulse; a new start after release completes correctly.
REQ-035 Back-to-back start held high -> operations accepted only in IDLE, one every WIDTH+2 cycles, each with a correct result.
